// File: rtl/score_counter.sv
// score_counter: frame-paced score for the renderer. The score goes up while the
// move button is held, freezes when the player collides, and clears on restart.
// Optional build macro: SCORE_COUNTER_HIGH_SCORE_EN keeps the best score since
// reset on o_high_score. Without it, o_high_score is tied to zero.
module score_counter #(
  parameter int unsigned FRAMES_PER_POINT = 8,
  parameter int unsigned MAX_SCORE        = 99,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_move,
  input  logic       i_collision,
  input  logic       i_restart,
  output logic [6:0] o_score,
  output logic       o_game_over,
  output logic [6:0] o_high_score
);

  localparam int unsigned CNT_W     = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
  localparam int unsigned SCORE_W   = 7;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(FRAMES_PER_POINT - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 move_s;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 game_over_q, game_over_d;

  assign move_s = sync_q[SYNC_STAGES-1];

  // Button synchroniser: shift the raw level through SYNC_STAGES flops
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_move};
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Restart beats collision, which beats everything else.
  always_comb begin
    state_d = state_q;
    if (i_restart) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (move_s)      state_d = ST_PLAY;
        ST_PLAY: if (i_collision) state_d = ST_OVER;
        ST_OVER: state_d = ST_OVER;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output/datapath next values. The hold counter is cleared unless it is held in PLAY.
  always_comb begin
    score_d     = score_q;
    cnt_d       = '0;
    game_over_d = (state_d == ST_OVER);
    if (i_restart) begin
      score_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: score_d = '0;
        ST_PLAY: begin
          if (!i_collision && move_s) begin
            cnt_d = cnt_q;
            if (i_frame_tick) begin
              if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (score_q < SCORE_MAX) score_d = score_q + SCORE_W'(1);
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and hold counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      score_q     <= '0;
      cnt_q       <= '0;
      game_over_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      cnt_q       <= cnt_d;
      game_over_q <= game_over_d;
    end
  end

  assign o_score     = score_q;
  assign o_game_over = game_over_q;

`ifdef SCORE_COUNTER_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q, high_d;

  // Capture the final score on a real PLAY->OVER transition, when restart is not also asserted
  always_comb begin
    high_d = high_q;
    if (!i_restart && (state_q == ST_PLAY) && i_collision && (score_q > high_q)) begin
      high_d = score_q;
    end
  end

  // High score survives restart; only reset clears it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      high_q <= '0;
    end else begin
      high_q <= high_d;
    end
  end

  assign o_high_score = high_q;
`else
  assign o_high_score = '0;
`endif

endmodule
